// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: host-side debug/loader bridge. Parses 'W'/'R' commands
// arriving as UART bytes, issues the matching bus cycle while holding the core
// off the bus with cpu_halt, and returns the response bytes to the transmitter.
//
// Handshakes: rx_valid is a one-cycle strobe and is only consumed in IDLE,
// ADDR and DATA (dropped elsewhere). tx_send is a one-cycle strobe issued only
// after tx_busy was observed low; tx_busy is then ignored for one cycle
// (RESP_GAP) because the transmitter raises it one cycle after tx_send.
// MemWrite is a single-cycle strobe; bus_rd is held READ_LATENCY cycles and
// HRDATA is sampled on the last of them.
module uart_bus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  output logic              MemWrite,
  output logic              bus_rd,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              cpu_halt,
  output logic              cmd_error,
  output logic [2:0]        dbg_state
);

  localparam int AB    = ADDR_W / 8;
  localparam int DB    = DATA_W / 8;
  localparam int CNT_W = 8;
  localparam int LAT_W = 3;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_RESP, S_RESP_GAP, S_RESP_WAIT
  } state_t;

  state_t            state, state_d;
  logic              is_wr, is_wr_d;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_d;
  logic [CNT_W-1:0]  resp_left, resp_left_d;
  logic [TO_W-1:0]   idle_cnt, idle_cnt_d;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
  logic [DATA_W-1:0] resp_sr, resp_sr_d;
  logic [7:0]        tx_data_d;
  logic              tx_send_d, mem_write_d, bus_rd_d, cpu_halt_d, cmd_error_d;
  logic [ADDR_W-1:0] haddr_d;
  logic [DATA_W-1:0] hwdata_d;

  assign dbg_state = state;

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      is_wr     <= 1'b0;
      byte_cnt  <= '0;
      resp_left <= '0;
      idle_cnt  <= '0;
      lat_cnt   <= '0;
      resp_sr   <= '0;
      tx_data   <= '0;
      tx_send   <= 1'b0;
      HADDR     <= '0;
      HWDATA    <= '0;
      MemWrite  <= 1'b0;
      bus_rd    <= 1'b0;
      cpu_halt  <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      state     <= state_d;
      is_wr     <= is_wr_d;
      byte_cnt  <= byte_cnt_d;
      resp_left <= resp_left_d;
      idle_cnt  <= idle_cnt_d;
      lat_cnt   <= lat_cnt_d;
      resp_sr   <= resp_sr_d;
      tx_data   <= tx_data_d;
      tx_send   <= tx_send_d;
      HADDR     <= haddr_d;
      HWDATA    <= hwdata_d;
      MemWrite  <= mem_write_d;
      bus_rd    <= bus_rd_d;
      cpu_halt  <= cpu_halt_d;
      cmd_error <= cmd_error_d;
    end
  end

  // Next-state and next-output logic. The BUS_WR cycle and the last BUS_RD
  // cycle start the first response byte directly when the transmitter is
  // idle, so the response follows the bus cycle without an extra RESP cycle.
  always_comb begin
    state_d     = state;
    is_wr_d     = is_wr;
    byte_cnt_d  = byte_cnt;
    resp_left_d = resp_left;
    idle_cnt_d  = idle_cnt;
    lat_cnt_d   = lat_cnt;
    resp_sr_d   = resp_sr;
    tx_data_d   = tx_data;
    tx_send_d   = 1'b0;
    haddr_d     = HADDR;
    hwdata_d    = HWDATA;
    mem_write_d = 1'b0;
    bus_rd_d    = 1'b0;
    cpu_halt_d  = cpu_halt;
    cmd_error_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          cpu_halt_d = 1'b1;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            is_wr_d = (rx_data == 8'h57);
            state_d = S_ADDR;
          end else begin
            cmd_error_d = 1'b1;
            resp_sr_d   = DATA_W'(8'h3F) << (DATA_W - 8);
            resp_left_d = CNT_W'(1);
            state_d     = S_RESP;
          end
        end
      end
      S_ADDR, S_DATA: begin
        // The timeout wins over a byte arriving in the same cycle.
        if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          cmd_error_d = 1'b1;
          cpu_halt_d  = 1'b0;
          state_d     = S_IDLE;
        end else if (rx_valid) begin
          idle_cnt_d = '0;
          byte_cnt_d = byte_cnt + 1'b1;
          if (state == S_ADDR) begin
            haddr_d = (HADDR << 8) | ADDR_W'(rx_data);
            if (byte_cnt == CNT_W'(AB - 1)) begin
              byte_cnt_d = '0;
              if (is_wr) begin
                state_d = S_DATA;
              end else begin
                bus_rd_d  = 1'b1;
                lat_cnt_d = '0;
                state_d   = S_BUS_RD;
              end
            end
          end else begin
            hwdata_d = (HWDATA << 8) | DATA_W'(rx_data);
            if (byte_cnt == CNT_W'(DB - 1)) begin
              byte_cnt_d  = '0;
              mem_write_d = 1'b1;
              state_d     = S_BUS_WR;
            end
          end
        end else begin
          idle_cnt_d = idle_cnt + 1'b1;
        end
      end
      S_BUS_WR: begin
        if (!tx_busy) begin
          tx_send_d   = 1'b1;
          tx_data_d   = 8'h4B;
          resp_left_d = '0;
          state_d     = S_RESP_GAP;
        end else begin
          resp_sr_d   = DATA_W'(8'h4B) << (DATA_W - 8);
          resp_left_d = CNT_W'(1);
          state_d     = S_RESP;
        end
      end
      S_BUS_RD: begin
        if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
          if (!tx_busy) begin
            tx_send_d   = 1'b1;
            tx_data_d   = HRDATA[DATA_W-1 -: 8];
            resp_sr_d   = HRDATA << 8;
            resp_left_d = CNT_W'(DB - 1);
            state_d     = S_RESP_GAP;
          end else begin
            resp_sr_d   = HRDATA;
            resp_left_d = CNT_W'(DB);
            state_d     = S_RESP;
          end
        end else begin
          bus_rd_d  = 1'b1;
          lat_cnt_d = lat_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (!tx_busy) begin
          tx_send_d   = 1'b1;
          tx_data_d   = resp_sr[DATA_W-1 -: 8];
          resp_sr_d   = resp_sr << 8;
          resp_left_d = resp_left - 1'b1;
          state_d     = S_RESP_GAP;
        end
      end
      S_RESP_GAP: state_d = S_RESP_WAIT;
      S_RESP_WAIT: begin
        if (!tx_busy) begin
          if (resp_left != '0) begin
            state_d = S_RESP;
          end else begin
            cpu_halt_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Testbench for uart_bus_bridge: directed command streams, a transmitter
// model for tx_busy, and a negedge monitor that pops expected queues.
module tb_uart_bus_bridge;

  localparam int RL       = 2;
  localparam int TO       = 50;
  localparam int TX_TIME  = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        MemWrite;
  logic        bus_rd;
  logic [31:0] HRDATA;
  logic        cpu_halt;
  logic        cmd_error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_byte_cyc = 0;
  logic hold_busy = 1'b0;

  // expected queues: values and the cycle they must appear in (-1 = any)
  logic [7:0]  exp_tx_q[$];
  int          exp_tx_cyc_q[$];
  logic [63:0] exp_wr_q[$];
  int          exp_wr_cyc_q[$];
  logic [31:0] exp_rd_q[$];
  int          exp_rd_cyc_q[$];
  int          exp_err_lo_q[$];
  int          exp_err_hi_q[$];

  uart_bus_bridge #(
    .ADDR_W(32), .DATA_W(32), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .HADDR(HADDR), .HWDATA(HWDATA), .MemWrite(MemWrite), .bus_rd(bus_rd),
    .HRDATA(HRDATA), .cpu_halt(cpu_halt), .cmd_error(cmd_error),
    .dbg_state(dbg_state)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endfunction

  // transmitter model: busy from the cycle after tx_send for TX_TIME cycles
  initial begin : tx_model
    int busy_cnt;
    logic pend;
    busy_cnt = 0;
    pend = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) busy_cnt--;
      if (pend) busy_cnt = TX_TIME;
      pend = tx_send;
      tx_busy = hold_busy || (busy_cnt > 0);
    end
  end

  // monitor / scoreboard
  int   rd_run = 0;
  logic prev_busy = 1'b0;
  logic prev_halt = 1'b0;
  logic prev_mw = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      rd_run    = 0;
      prev_busy = 1'b0;
      prev_halt = 1'b0;
      prev_mw   = 1'b0;
    end else begin
      if (tx_send) begin
        chk("tx_send_after_busy_low", prev_busy, 1'b0);
        if (exp_tx_q.size() == 0) unexpected("tx_send");
        else begin
          int ec;
          chk("tx_data", tx_data, exp_tx_q.pop_front());
          ec = exp_tx_cyc_q.pop_front();
          if (ec >= 0) chk("tx_latency", cyc, ec);
        end
      end
      if (MemWrite) begin
        chk("memwrite_halted", prev_halt, 1'b1);
        chk("memwrite_single", prev_mw, 1'b0);
        if (exp_wr_q.size() == 0) unexpected("MemWrite");
        else begin
          chk("write_addr_data", {HADDR, HWDATA}, exp_wr_q.pop_front());
          chk("write_latency", cyc, exp_wr_cyc_q.pop_front());
        end
      end
      if (bus_rd) begin
        if (rd_run == 0) begin
          chk("bus_rd_halted", prev_halt, 1'b1);
          if (exp_rd_q.size() == 0) unexpected("bus_rd");
          else begin
            chk("read_addr", HADDR, exp_rd_q.pop_front());
            chk("bus_rd_start", cyc, exp_rd_cyc_q.pop_front());
          end
        end
        rd_run++;
      end else if (rd_run != 0) begin
        chk("bus_rd_length", rd_run, RL);
        rd_run = 0;
      end
      if (cmd_error) begin
        if (exp_err_lo_q.size() == 0) unexpected("cmd_error");
        else begin
          int lo, hi;
          lo = exp_err_lo_q.pop_front();
          hi = exp_err_hi_q.pop_front();
          chk("cmd_error_cycle_in_window", (cyc >= lo && cyc <= hi), 1'b1);
        end
      end
      prev_busy = tx_busy;
      prev_halt = cpu_halt;
      prev_mw   = MemWrite;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    last_byte_cyc = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(dbg_state == 3'd0 && exp_tx_q.size() == 0 && !tx_busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) unexpected({name, "_idle_timeout"});
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_cpu_halt_released"}, cpu_halt, 1'b0);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n;
    n = 0;
    while (dbg_state != s && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) unexpected({name, "_state_timeout"});
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    chk("cpu_halt_after_opcode", cpu_halt, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    exp_wr_q.push_back({a, d});
    exp_wr_cyc_q.push_back(last_byte_cyc + 1);
    exp_tx_q.push_back(8'h4B);
    exp_tx_cyc_q.push_back(last_byte_cyc + 2);
    wait_idle("write");
  endtask

  // nbytes: how many response bytes are expected; timed: first byte latency known
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int nbytes,
                         input bit timed);
    send_byte(8'h52);
    chk("cpu_halt_after_opcode", cpu_halt, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    exp_rd_q.push_back(a);
    exp_rd_cyc_q.push_back(last_byte_cyc + 1);
    for (int i = 0; i < nbytes; i++) begin
      exp_tx_q.push_back(d[(3-i)*8 +: 8]);
      exp_tx_cyc_q.push_back((timed && i == 0) ? last_byte_cyc + RL + 1 : -1);
    end
  endtask

  task automatic reset_and_check(input string name);
    #2;
    reset = 1'b0;
    #1;
    chk({name, "_tx_data"}, tx_data, 8'h00);
    chk({name, "_tx_send"}, tx_send, 1'b0);
    chk({name, "_HADDR"}, HADDR, 32'h0);
    chk({name, "_HWDATA"}, HWDATA, 32'h0);
    chk({name, "_MemWrite"}, MemWrite, 1'b0);
    chk({name, "_bus_rd"}, bus_rd, 1'b0);
    chk({name, "_cpu_halt"}, cpu_halt, 1'b0);
    chk({name, "_cmd_error"}, cmd_error, 1'b0);
    chk({name, "_state"}, dbg_state, 3'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    HRDATA   = 32'h0;
    #3;
    reset_and_check("reset");
    repeat (2) @(posedge clk);

    // write
    do_write(32'h0000_1004, 32'hDEAD_BEEF);

    // read, transmitter idle
    HRDATA = 32'h1234_5678;
    do_read(32'h0000_2000, 32'h1234_5678, 4, 1'b1);
    wait_idle("read");

    // unknown opcode
    send_byte(8'hA5);
    exp_err_lo_q.push_back(last_byte_cyc + 1);
    exp_err_hi_q.push_back(last_byte_cyc + 1);
    exp_tx_q.push_back(8'h3F);
    exp_tx_cyc_q.push_back(-1);
    wait_idle("bad_opcode");

    // timeout after a partial write, then a normal read
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    exp_err_lo_q.push_back(last_byte_cyc + TO);
    exp_err_hi_q.push_back(last_byte_cyc + TO + 2);
    repeat (TO + 10) @(posedge clk);
    #1;
    chk("timeout_error_seen", exp_err_lo_q.size(), 0);
    chk("timeout_state_idle", dbg_state, 3'd0);
    chk("timeout_cpu_halt", cpu_halt, 1'b0);
    HRDATA = 32'hCAFE_F00D;
    do_read(32'h0000_0040, 32'hCAFE_F00D, 4, 1'b1);
    wait_idle("read_after_timeout");

    // reset in the middle of the data field
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte((i == 3) ? 8'h08 : 8'h00);
    send_byte(8'hAA);
    reset_and_check("rst_mid_data");
    do_write(32'h0000_0008, 32'h1122_3344);

    // reset while waiting on the transmitter between response bytes
    HRDATA = 32'h5566_7788;
    do_read(32'h0000_000C, 32'h5566_7788, 1, 1'b1);
    wait_state(3'd7, "resp_wait");
    reset_and_check("rst_mid_resp");
    repeat (TX_TIME + 40) @(posedge clk);
    wait_idle("after_rst_resp");
    do_write(32'h0000_0100, 32'h0BAD_F00D);

    // transmitter held busy for 200 cycles; stray bytes must be dropped
    hold_busy = 1'b1;
    repeat (3) @(posedge clk);
    HRDATA = 32'hA1B2_C3D4;
    do_read(32'h0000_3000, 32'hA1B2_C3D4, 4, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    HRDATA = 32'hFFFF_FFFF;
    send_byte(8'h57);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'hA5);
    repeat (170) @(posedge clk);
    #1;
    chk("held_no_bytes_sent", exp_tx_q.size(), 4);
    hold_busy = 1'b0;
    wait_idle("held_read");
    repeat (TO + 20) @(posedge clk);
    #1;
    chk("stray_bytes_dropped_state", dbg_state, 3'd0);

    // nothing left outstanding
    chk("tx_queue_empty", exp_tx_q.size(), 0);
    chk("wr_queue_empty", exp_wr_q.size(), 0);
    chk("rd_queue_empty", exp_rd_q.size(), 0);
    chk("err_queue_empty", exp_err_lo_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
Host-side debug/loader bridge. It turns the byte stream from the UART receiver into bus reads and writes on the HADDR/HWDATA/HRDATA bus, and returns responses through the UART transmitter. The core issues bus cycles toward the UART; this block issues bus cycles from the UART. It sits beside RISC_V, muxed onto the PCH master port, and holds the core via cpu_halt while it owns the bus.

Parameters:
ADDR_W, 32, bus address width (multiple of 8)
DATA_W, 32, bus data width (multiple of 8)
READ_LATENCY, 1, cycles from bus_rd assertion to valid HRDATA (1..7)
TIMEOUT_CYCLES, 1000000, idle clocks between command bytes before the parser aborts

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to UART transmitter
tx_send  out  1  one-cycle strobe, start transmission of tx_data
tx_busy  in  1  transmitter busy; rises the cycle after tx_send
HADDR  out  ADDR_W  bus address
HWDATA  out  DATA_W  bus write data
MemWrite  out  1  one-cycle bus write strobe
bus_rd  out  1  bus read request, held READ_LATENCY cycles
HRDATA  in  DATA_W  bus read data
cpu_halt  out  1  core stall/bus ownership request
cmd_error  out  1  one-cycle pulse on unknown opcode or timeout

Behaviour:
- One clock domain. Reset is asynchronous and active-low (reset=0 resets). All outputs are registered.
- Reset values: tx_data=0, tx_send=0, HADDR=0, HWDATA=0, MemWrite=0, bus_rd=0, cpu_halt=0, cmd_error=0. State returns to IDLE and all counters clear. Reset mid-command discards the command and emits no response.
- Protocol: all multi-byte fields are MSB first.
  - 'W' (0x57): followed by ADDR_W/8 address bytes, then DATA_W/8 data bytes. The bridge performs the bus write and responds 0x4B ('K').
  - 'R' (0x52): followed by ADDR_W/8 address bytes. The bridge responds with DATA_W/8 data bytes, MSB first.
  - Any other opcode: respond 0x3F ('?') and pulse cmd_error.
- States:
  - IDLE: wait for rx_valid.
  - ADDR: shift rx_data into the address register on each rx_valid; byte counter.
  - DATA: shift into the data register ('W' only).
  - BUS_WR: MemWrite=1 for exactly 1 cycle, with HADDR/HWDATA stable that cycle.
  - BUS_RD: bus_rd=1 for READ_LATENCY cycles; HRDATA is captured into the response shift register on the last of those cycles.
  - RESP: if tx_busy=0, drive tx_data and pulse tx_send.
  - RESP_GAP: one cycle, ignore tx_busy; then go to RESP_WAIT.
  - RESP_WAIT: wait for tx_busy=0. If more response bytes remain, go to RESP; otherwise go to IDLE.
- cpu_halt: set on the cycle the opcode byte is accepted; cleared on entering IDLE. The bus strobes are asserted only when cpu_halt has already been 1 for at least one cycle.
- rx_valid while in BUS_WR, BUS_RD, RESP, RESP_GAP or RESP_WAIT is dropped (no buffering).
- Timeout: an idle counter clears on each rx_valid and is active only in ADDR/DATA. When it reaches TIMEOUT_CYCLES: pulse cmd_error, no response, go to IDLE, deassert cpu_halt.
- Byte counters and shift registers wrap exactly at the field width; no extra bytes are consumed. A byte arriving the same cycle a timeout fires is discarded, and the timeout wins.
- Latency:
  - Write: MemWrite occurs 1 cycle after the last data byte's rx_valid. tx_send for 'K' occurs 1 cycle after MemWrite if tx_busy=0.
  - Read: first tx_send occurs READ_LATENCY+1 cycles after the last address byte.

Test Plan:
- Write: bytes 57 00 00 10 04 DE AD BE EF -> one MemWrite with HADDR=0x00001004, HWDATA=0xDEADBEEF, then tx_send with tx_data=0x4B. cpu_halt is high from the first byte until return to IDLE.
- Read: bytes 52 00 00 20 00 with HRDATA=0x12345678 after latency -> four tx_send pulses, tx_data 12,34,56,78. Each pulse waits for tx_busy low. bus_rd is high for exactly READ_LATENCY cycles.
- Bad opcode 0xA5 -> cmd_error pulse, tx_data=0x3F, no MemWrite/bus_rd, cpu_halt drops after the response.
- Timeout (TIMEOUT_CYCLES=50): 57 00 00 then 50 idle cycles -> cmd_error pulse, IDLE, cpu_halt=0. A following complete 'R' command executes normally.
- Reset low mid-DATA and mid-RESP_WAIT -> all outputs zero immediately (asynchronous), no response; after release, a full 'W' command succeeds.
- tx_busy held high for 200 cycles during a read response -> no tx_send until it falls, bytes are not lost or reordered, and extra rx_valid pulses during the response are ignored.
